// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the opcode/func encodings used by the loader, the NOP word emitted
// for anything unencodable, the session FSM state type and a sign-range
// helper used when ENC_RANGE_CHK_EN is defined.
package instr_encoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IM     = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL_R  = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_EXEC   = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] ENC_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } enc_state_e;

  // True when v[31:msb] are all copies of v[msb], i.e. v fits in msb+1 signed bits.
  function automatic logic upper_same(input logic [31:0] v, input int unsigned msb);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i > msb && v[i] != v[msb]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// rv_pack: combinational RV32I field packer.
// Ports: i_op/i_func3/i_func7/i_rd/i_rs1/i_rs2/i_imm field inputs;
//        o_word packed instruction (NOP when o_bad); o_bad unsupported
//        opcode/func combination or (with ENC_RANGE_CHK_EN) immediate range fault.
// Macro: ENC_RANGE_CHK_EN enables immediate range checking; otherwise
//        immediates are silently truncated to their field widths.
module rv_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  i_op,
  input  logic [2:0]  i_func3,
  input  logic [6:0]  i_func7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_bad
);

  logic [31:0] w_word;
  logic        w_func_bad;
  logic        w_range_bad;
  logic        w_shift;

  assign w_shift = (i_func3 == F3_SLL) || (i_func3 == F3_SR);

  always_comb begin
    w_word     = ENC_NOP;
    w_func_bad = 1'b0;
    case (i_op)
      OP_R: begin
        w_word     = {i_func7, i_rs2, i_rs1, i_func3, i_rd, i_op};
        // Alternate func7 only exists for SUB and SRA.
        w_func_bad = !((i_func7 == F7_BASE) ||
                       (i_func7 == F7_ALT && (i_func3 == F3_ADD || i_func3 == F3_SR)));
      end
      OP_IM: begin
        if (w_shift) begin
          w_word     = {i_func7, i_imm[4:0], i_rs1, i_func3, i_rd, i_op};
          w_func_bad = !((i_func7 == F7_BASE) || (i_func3 == F3_SR && i_func7 == F7_ALT));
        end else begin
          w_word = {i_imm[11:0], i_rs1, i_func3, i_rd, i_op};
        end
      end
      OP_LOAD: begin
        w_word     = {i_imm[11:0], i_rs1, i_func3, i_rd, i_op};
        w_func_bad = (i_func3 == 3'b011) || (i_func3 == 3'b110) || (i_func3 == 3'b111);
      end
      OP_JAL_R: begin
        w_word     = {i_imm[11:0], i_rs1, i_func3, i_rd, i_op};
        w_func_bad = (i_func3 != F3_ADD);
      end
      OP_STORE: begin
        w_word     = {i_imm[11:5], i_rs2, i_rs1, i_func3, i_imm[4:0], i_op};
        w_func_bad = i_func3[2] || (i_func3 == 3'b011);
      end
      OP_BRANCH: begin
        w_word     = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_func3, i_imm[4:1], i_imm[11], i_op};
        w_func_bad = (i_func3 == 3'b010) || (i_func3 == 3'b011);
      end
      OP_LUI, OP_AUIPC: begin
        w_word = {i_imm[31:12], i_rd, i_op};
      end
      OP_JAL: begin
        w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op};
      end
      default: w_func_bad = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHK_EN
  always_comb begin
    w_range_bad = 1'b0;
    case (i_op)
      OP_IM:                       w_range_bad = w_shift ? (|i_imm[31:5]) : !upper_same(i_imm, 11);
      OP_LOAD, OP_JAL_R, OP_STORE: w_range_bad = !upper_same(i_imm, 11);
      OP_BRANCH:                   w_range_bad = !upper_same(i_imm, 12) || i_imm[0];
      OP_JAL:                      w_range_bad = !upper_same(i_imm, 20) || i_imm[0];
      OP_LUI, OP_AUIPC:            w_range_bad = |i_imm[11:0];
      default:                     w_range_bad = 1'b0;
    endcase
  end
`else
  assign w_range_bad = 1'b0;
`endif

  assign o_bad  = w_func_bad || w_range_bad;
  assign o_word = o_bad ? ENC_NOP : w_word;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams RV32I field sets in, writes packed words to
// consecutive IMEM word addresses through a one-entry output register.
// Ports: clk/rst (async, active-high); start/cfg_base open a session;
//        in_* valid/ready field stream with in_last; imem_we/addr/wdata
//        held until imem_ready; busy, done pulse, word_cnt, sticky err.
// Macro: ENC_RANGE_CHK_EN (see rv_pack) enables immediate range checks.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] cfg_base,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [6:0]    in_op,
  input  logic [2:0]    in_func3,
  input  logic [6:0]    in_func7,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic [15:0]   word_cnt,
  output logic          err
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);

  enc_state_e    r_state;
  enc_state_e    w_next;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [15:0]   r_word_cnt;
  logic [CW-1:0] r_acc_cnt;
  logic          r_err;

  logic [31:0]   w_word;
  logic          w_bad;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_wr;

  rv_pack u_pack (
    .i_op    (in_op),
    .i_func3 (in_func3),
    .i_func7 (in_func7),
    .i_rd    (in_rd),
    .i_rs1   (in_rs1),
    .i_rs2   (in_rs2),
    .i_imm   (in_imm),
    .o_word  (w_word),
    .o_bad   (w_bad)
  );

  assign w_accept = in_valid && w_in_ready;
  assign w_wr     = r_we && imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_RUN;
      ST_RUN:   if (w_accept && in_last) w_next = ST_DRAIN;
      ST_DRAIN: if (!r_we) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    // Output slot is free if empty or draining this cycle, so accept and
    // drain can overlap and sustain one word per cycle.
    w_in_ready = (r_state == ST_RUN) && (!r_we || imem_ready) &&
                 (r_acc_cnt < CW'(MAX_WORDS));
    busy       = (r_state != ST_IDLE);
    done       = (r_state == ST_DRAIN) && !r_we;
  end

  // r_addr always tracks the address of the word in (or next entering) the
  // output register; it steps only when IMEM takes a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word_cnt <= '0;
      r_acc_cnt  <= '0;
      r_err      <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        r_addr     <= cfg_base;
        r_word_cnt <= '0;
        r_acc_cnt  <= '0;
        r_err      <= 1'b0;
      end
    end else begin
      if (w_wr) begin
        r_word_cnt <= r_word_cnt + 16'd1;
        r_addr     <= r_addr + AW'(4);
      end
      if (w_accept) begin
        r_wdata   <= w_word;
        r_acc_cnt <= r_acc_cnt + CW'(1);
        if (w_bad) r_err <= 1'b1;
      end
      if (w_accept)  r_we <= 1'b1;
      else if (w_wr) r_we <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_cnt   = r_word_cnt;
  assign err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] cfg_base;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [6:0]  in_op;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        imem_we;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[9];

  instr_encoder #(.AW(32), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_base   (cfg_base),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_op      (in_op),
    .in_func3   (in_func3),
    .in_func7   (in_func7),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .word_cnt   (word_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    in_op = op; in_func3 = f3; in_func7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic start_session(input logic [31:0] base);
    cfg_base = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_base = '0; in_valid = 1'b0; in_last = 1'b0;
    imem_ready = 1'b0;
    drive(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, imem_we, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {in_ready, imem_we, busy, done, err});
    end
    checks++;
    if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || word_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h cnt=%0d want zeros", imem_addr, imem_wdata, word_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_formats();
    int ndone;
    vt[0] = '{7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093};
    vt[1] = '{7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,         32'h002081B3};
    vt[2] = '{7'h13, 3'd5, 7'h20, 5'd4, 5'd4, 5'd0, 32'd3,         32'h40325213};
    vt[3] = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h00208463};
    vt[4] = '{7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd16,        32'h010000EF};
    vt[5] = '{7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7};
    vt[6] = '{7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd12,        32'h0020A623};
    vt[7] = '{7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF,  32'hFFF00093};
    vt[8] = '{7'h63, 3'd1, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,  32'hFE209EE3};
    imem_ready = 1'b1;
    start_session(32'h100);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 32'h100 + 32'(4 * (i - 1)) || imem_wdata !== vt[i-1].exp) begin
          errors++;
          $display("FAIL fmt_word%0d: got we=%b addr=%h data=%h want 1 %h %h", i - 1,
                   imem_we, imem_addr, imem_wdata, 32'h100 + 32'(4 * (i - 1)), vt[i-1].exp);
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fmt_ready%0d: got %b want 1", i, in_ready);
      end
      drive(vt[i].op, vt[i].f3, vt[i].f7, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm);
      in_valid = 1'b1;
      in_last = (i == 8);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h120 || imem_wdata !== vt[8].exp) begin
      errors++;
      $display("FAIL fmt_word8: got we=%b addr=%h data=%h want 1 00000120 %h", imem_we, imem_addr, imem_wdata, vt[8].exp);
    end
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL fmt_done: got %0d pulses want 1", ndone);
    end
    checks++;
    if (busy !== 1'b0 || word_cnt !== 16'd9 || err !== 1'b0) begin
      errors++;
      $display("FAIL fmt_end: got busy=%b cnt=%0d err=%b want 0 9 0", busy, word_cnt, err);
    end
  endtask

  task automatic test_illegal();
    int ndone;
    start_session(32'h180);
    imem_ready = 1'b1;
    drive(7'h33, 3'd0, 7'h01, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_wdata !== 32'h00000013 || err !== 1'b1) begin
      errors++;
      $display("FAIL ill_rtype: got data=%h err=%b want 00000013 1", imem_wdata, err);
    end
    drive(7'h03, 3'd3, 7'h00, 5'd3, 5'd1, 5'd0, 32'd4);
    @(negedge clk);
    checks++;
    if (imem_wdata !== 32'h00000013 || imem_addr !== 32'h184) begin
      errors++;
      $display("FAIL ill_load: got data=%h addr=%h want 00000013 00000184", imem_wdata, imem_addr);
    end
    drive(7'h0F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (imem_wdata !== 32'h00000013 || err !== 1'b1) begin
      errors++;
      $display("FAIL ill_fence: got data=%h err=%b want 00000013 1", imem_wdata, err);
    end
    for (int c = 0; c < 6; c++) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL ill_sticky: got busy=%b err=%b want 0 1", busy, err);
    end
    start_session(32'h1C0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL ill_clear: got err=%b want 0", err);
    end
    drive(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ill_close: got done=%0d busy=%b want 1 0", ndone, busy);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] exp[6];
    int wr, sent, stalls, ndone;
    exp[0] = 32'h00100093; exp[1] = 32'h00200113; exp[2] = 32'h00300193;
    exp[3] = 32'h00400213; exp[4] = 32'h00500293; exp[5] = 32'h00600313;
    wr = 0; sent = 0; stalls = 0; ndone = 0;
    imem_ready = 1'b1;
    start_session(32'h200);
    for (int c = 0; c < 40; c++) begin
      imem_ready = !(wr == 2 && stalls < 3);
      if (sent < 6) begin
        drive(7'h13, 3'd0, 7'h00, 5'(sent + 1), 5'd0, 5'd0, 32'(sent + 1));
        in_valid = 1'b1;
        in_last = (sent == 5);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      #1;
      if (done) ndone++;
      if (imem_we) begin
        checks++;
        if (wr >= 6) begin
          errors++;
          $display("FAIL stall_extra: got write %0d addr=%h want at most 6 writes", wr, imem_addr);
        end else if (imem_addr !== 32'h200 + 32'(4 * wr) || imem_wdata !== exp[wr]) begin
          errors++;
          $display("FAIL stall_word%0d: got addr=%h data=%h want %h %h", wr, imem_addr, imem_wdata,
                   32'h200 + 32'(4 * wr), exp[wr]);
        end
        if (!imem_ready) begin
          stalls++;
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: got in_ready=%b want 0", in_ready);
          end
        end else begin
          wr++;
        end
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (wr !== 6 || sent !== 6 || stalls !== 3) begin
      errors++;
      $display("FAIL stall_counts: got wr=%0d sent=%0d stalls=%0d want 6 6 3", wr, sent, stalls);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL stall_done: got %0d pulses want 1", ndone);
    end
    checks++;
    if (word_cnt !== 16'd6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got cnt=%0d busy=%b want 6 0", word_cnt, busy);
    end
  endtask

  task automatic test_wrap_and_range();
    logic [31:0] exp2;
    logic        exp_err;
`ifdef ENC_RANGE_CHK_EN
    exp2 = 32'h00000013; exp_err = 1'b1;
`else
    exp2 = 32'h80000093; exp_err = 1'b0;
`endif
    imem_ready = 1'b1;
    start_session(32'hFFFFFFFC);
    drive(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'hFFFFFFFC || imem_wdata !== 32'h00500093) begin
      errors++;
      $display("FAIL wrap_first: got addr=%h data=%h want fffffffc 00500093", imem_addr, imem_wdata);
    end
    drive(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
    in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h00000000 || imem_wdata !== exp2) begin
      errors++;
      $display("FAIL wrap_second: got we=%b addr=%h data=%h want 1 00000000 %h", imem_we, imem_addr, imem_wdata, exp2);
    end
    for (int c = 0; c < 5; c++) @(negedge clk);
    checks++;
    if (err !== exp_err || word_cnt !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL range_err: got err=%b cnt=%0d busy=%b want %b 2 0", err, word_cnt, busy, exp_err);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    imem_ready = 1'b0;
    start_session(32'h300);
    cfg_base = 32'h500;
    start = 1'b1;
    drive(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h300 || imem_wdata !== 32'h00500093) begin
      errors++;
      $display("FAIL mid_pending: got we=%b addr=%h data=%h want 1 00000300 00500093", imem_we, imem_addr, imem_wdata);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, imem_we, busy, done, err} !== 5'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0 || word_cnt !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: got flags=%b addr=%h data=%h cnt=%0d want zeros",
               {in_ready, imem_we, busy, done, err}, imem_addr, imem_wdata, word_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    start_session(32'h400);
    drive(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd7);
    in_valid = 1'b1; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h400 || imem_wdata !== 32'h00700113) begin
      errors++;
      $display("FAIL clean_word: got we=%b addr=%h data=%h want 1 00000400 00700113", imem_we, imem_addr, imem_wdata);
    end
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1 || word_cnt !== 16'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL clean_end: got done=%0d cnt=%0d err=%b want 1 1 0", ndone, word_cnt, err);
    end
  endtask

  task automatic test_limit();
    int acc, ndone;
    imem_ready = 1'b1;
    start_session(32'h1000);
    drive(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 1200 && acc < 1024; c++) begin
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    checks++;
    if (acc !== 1024) begin
      errors++;
      $display("FAIL limit_accepts: got %0d want 1024", acc);
    end
    in_last = 1'b1;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL limit_ready: got in_ready=%b want 0", in_ready);
      end
      if (done) ndone++;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (word_cnt !== 16'd1024 || busy !== 1'b1 || imem_we !== 1'b0 || ndone !== 0) begin
      errors++;
      $display("FAIL limit_state: got cnt=%0d busy=%b we=%b done=%0d want 1024 1 0 0", word_cnt, busy, imem_we, ndone);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL limit_abort: got busy=%b cnt=%0d want 0 0", busy, word_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_illegal();
    test_back_to_back_stall();
    test_wrap_and_range();
    test_reset_mid_run();
    test_limit();
    if (errors == 0) $display("PASS");
    else             $display("FAIL");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
